// File: rtl/snn_pkg.sv
// Shared types, widths and rectifier helpers for the parametrised SNN inference core.
package snn_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_H_MAC,
    S_H_DRAIN,
    S_H_LUT,
    S_H_WR,
    S_O_MAC,
    S_O_DRAIN,
    S_O_LUT,
    S_O_CMP,
    S_DONE
  } state_e;

  // Address width for an n-entry space; never collapses to zero bits
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  function automatic int unsigned lut_offset(input int unsigned aw);
    return 32'd1 << (aw - 32'd1);
  endfunction

  function automatic int sat_hi(input int unsigned aw);
    return (32'sd1 <<< (aw - 32'd1)) - 32'sd1;
  endfunction

  function automatic int sat_lo(input int unsigned aw);
    return -(32'sd1 <<< (aw - 32'd1));
  endfunction

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned N_IN_DEF    = 784;
  localparam int unsigned N_HID_DEF   = 32;
  localparam int unsigned N_OUT_DEF   = 10;
  localparam int unsigned LUT_AW_DEF  = 11;
  localparam int unsigned IN_AW_DEF   = addr_w(N_IN_DEF);
  localparam int unsigned HID_AW_DEF  = addr_w(N_HID_DEF);
  localparam int unsigned OUT_AW_DEF  = addr_w(N_OUT_DEF);
  localparam int unsigned LUT_OFF_DEF = lut_offset(LUT_AW_DEF);

endpackage

// File: rtl/snn_mac.sv
// Signed multiply-accumulate; exposes the next accumulator value so the rectifier can sample it.
module snn_mac #(
  parameter int unsigned W_W   = 8,
  parameter int unsigned ACC_W = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [W_W-1:0]   a,
  input  logic signed [W_W-1:0]   w,
  output logic signed [ACC_W-1:0] acc_nxt_c
);

  logic signed [ACC_W-1:0] acc;
  logic signed [2*W_W-1:0] prod_c;

  always_comb begin
    prod_c    = (2*W_W)'(a) * (2*W_W)'(w);
    acc_nxt_c = acc + ACC_W'(prod_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_nxt_c;
  end

endmodule

// File: rtl/snn_core_param.sv
// Two-layer bitmap classifier: hidden MAC, activation LUT, output MAC, argmax.
// Optional per-class score stream under SNN_SCORE_OUT_EN.
module snn_core_param
  import snn_pkg::*;
#(
  parameter int unsigned N_IN   = 784,
  parameter int unsigned N_HID  = 32,
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned W_W    = 8,
  parameter int unsigned ACC_W  = 26,
  parameter int unsigned FRAC   = 7,
  parameter int unsigned LUT_AW = 11
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  output logic [DIGIT_W-1:0]                      digit,
  output logic [W_W-1:0]                          max_score,
  output logic [addr_w(N_IN)-1:0]                 in_addr,
  input  logic                                    in_q,
  output logic [addr_w(N_HID)+addr_w(N_IN)-1:0]   hw_addr,
  input  logic [W_W-1:0]                          hw_q,
  output logic [addr_w(N_OUT)+addr_w(N_HID)-1:0]  ow_addr,
  input  logic [W_W-1:0]                          ow_q,
  output logic [LUT_AW-1:0]                       lut_addr,
  input  logic [W_W-1:0]                          lut_q
`ifdef SNN_SCORE_OUT_EN
  ,
  output logic                                    score_vld,
  output logic [DIGIT_W-1:0]                      score_idx,
  output logic [W_W-1:0]                          score
`endif
);

  localparam int unsigned IN_AW  = addr_w(N_IN);
  localparam int unsigned HID_AW = addr_w(N_HID);
  localparam int unsigned OUT_AW = addr_w(N_OUT);
  localparam logic signed [W_W-1:0]   A_ONE   = W_W'(sat_hi(W_W));
  localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'(sat_hi(LUT_AW));
  localparam logic signed [ACC_W-1:0] SAT_LO  = ACC_W'(sat_lo(LUT_AW));
  localparam logic [LUT_AW-1:0]       LUT_OFF = LUT_AW'(lut_offset(LUT_AW));

  state_e state, state_nxt;
  logic [IN_AW-1:0]  i;
  logic [HID_AW-1:0] h;
  logic [OUT_AW-1:0] o;
  logic i_last, h_last, o_last;
  logic issue_c, clr_c, lut_ld_c, hwr_c, cmp_c, fin_c, accept_c, out_layer_c;
  logic i_clr_c, i_inc_c, h_clr_c, h_inc_c, o_clr_c, o_inc_c;
  logic issue_q;
  logic signed [W_W-1:0]   hram [N_HID];
  logic signed [W_W-1:0]   hram_q, mac_a_c, mac_w_c;
  logic signed [ACC_W-1:0] acc_nxt_c, acc_sh_c;
  logic [LUT_AW-1:0]       rect_c;
  logic [W_W-1:0]          max_run;
  logic [DIGIT_W-1:0]      idx_run;

  assign i_last  = (i == IN_AW'(N_IN - 1));
  assign h_last  = (h == HID_AW'(N_HID - 1));
  assign o_last  = (o == OUT_AW'(N_OUT - 1));
  assign in_addr = i;
  assign hw_addr = {h, i};
  assign ow_addr = {o, h};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_H_MAC;
      S_H_MAC:   if (i_last) state_nxt = S_H_DRAIN;
      S_H_DRAIN: state_nxt = S_H_LUT;
      S_H_LUT:   state_nxt = S_H_WR;
      S_H_WR:    state_nxt = h_last ? S_O_MAC : S_H_MAC;
      S_O_MAC:   if (h_last) state_nxt = S_O_DRAIN;
      S_O_DRAIN: state_nxt = S_O_LUT;
      S_O_LUT:   state_nxt = S_O_CMP;
      S_O_CMP:   state_nxt = o_last ? S_DONE : S_O_MAC;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue_c = 1'b0; clr_c = 1'b0; lut_ld_c = 1'b0; hwr_c = 1'b0;
    cmp_c = 1'b0; fin_c = 1'b0; accept_c = 1'b0;
    i_clr_c = 1'b0; i_inc_c = 1'b0; h_clr_c = 1'b0; h_inc_c = 1'b0;
    o_clr_c = 1'b0; o_inc_c = 1'b0;
    out_layer_c = (state == S_O_MAC) || (state == S_O_DRAIN);
    unique case (state)
      S_IDLE: begin
        clr_c = 1'b1; i_clr_c = 1'b1; h_clr_c = 1'b1; o_clr_c = 1'b1;
        accept_c = start;
      end
      S_H_MAC:              begin issue_c = 1'b1; i_inc_c = !i_last; end
      S_H_DRAIN, S_O_DRAIN: lut_ld_c = 1'b1;
      S_H_WR: begin
        hwr_c = 1'b1; clr_c = 1'b1; i_clr_c = 1'b1;
        h_inc_c = !h_last; h_clr_c = h_last;
      end
      S_O_MAC:              begin issue_c = 1'b1; h_inc_c = !h_last; end
      S_O_CMP: begin
        cmp_c = 1'b1; clr_c = 1'b1; h_clr_c = 1'b1; o_inc_c = !o_last;
      end
      S_DONE:               fin_c = 1'b1;
      default: ;
    endcase
  end

  // Operand select: data returned this cycle belongs to the address issued last cycle
  always_comb begin
    mac_a_c = out_layer_c ? hram_q : (in_q ? A_ONE : '0);
    mac_w_c = out_layer_c ? $signed(ow_q) : $signed(hw_q);
  end

  snn_mac #(.W_W(W_W), .ACC_W(ACC_W)) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_c),
    .en        (issue_q),
    .a         (mac_a_c),
    .w         (mac_w_c),
    .acc_nxt_c (acc_nxt_c)
  );

  // Saturating slice of the final accumulator, taken as the last product lands
  always_comb begin
    acc_sh_c = acc_nxt_c >>> FRAC;
    if (acc_sh_c > SAT_HI)      rect_c = LUT_AW'(SAT_HI);
    else if (acc_sh_c < SAT_LO) rect_c = LUT_AW'(SAT_LO);
    else                        rect_c = acc_nxt_c[FRAC+LUT_AW-1:FRAC];
  end

  always_ff @(posedge clk) begin
    if (hwr_c) hram[h] <= lut_q;
    hram_q <= hram[h];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0; h <= '0; o <= '0;
      issue_q <= 1'b0; lut_addr <= '0;
      max_run <= '0; idx_run <= '0;
      busy <= 1'b0; done <= 1'b0; digit <= '0; max_score <= '0;
    end else begin
      issue_q <= issue_c;
      if (i_clr_c)      i <= '0;
      else if (i_inc_c) i <= i + IN_AW'(1);
      if (h_clr_c)      h <= '0;
      else if (h_inc_c) h <= h + HID_AW'(1);
      if (o_clr_c)      o <= '0;
      else if (o_inc_c) o <= o + OUT_AW'(1);
      if (lut_ld_c) lut_addr <= rect_c + LUT_OFF;
      // Strictly-greater update keeps the lowest index on ties
      if (cmp_c && ((o == '0) || (lut_q > max_run))) begin
        max_run <= lut_q;
        idx_run <= DIGIT_W'(o);
      end
      if (accept_c)   busy <= 1'b1;
      else if (fin_c) busy <= 1'b0;
      done <= fin_c;
      if (fin_c) begin
        digit     <= idx_run;
        max_score <= max_run;
      end
    end
  end

`ifdef SNN_SCORE_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_vld <= 1'b0; score_idx <= '0; score <= '0;
    end else begin
      score_vld <= cmp_c;
      if (cmp_c) begin
        score_idx <= DIGIT_W'(o);
        score     <= lut_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_snn_core_param.sv
// Directed bench: small hand-computed config plus default-size latency, tie, saturation and abort runs.
module tb_snn_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-size instance
  logic rst_n_d, start_d, busy_d, done_d, in_q_d;
  logic [3:0]  digit_d;
  logic [7:0]  max_d, hw_q_d, ow_q_d, lut_q_d;
  logic [9:0]  in_addr_d;
  logic [14:0] hw_addr_d;
  logic [8:0]  ow_addr_d;
  logic [10:0] lut_addr_d;
  // small instance
  logic rst_n_s, start_s, busy_s, done_s, in_q_s;
  logic [3:0] digit_s;
  logic [7:0] max_s, hw_q_s, ow_q_s, lut_q_s, lut_addr_s;
  logic [1:0] in_addr_s;
  logic [2:0] hw_addr_s, ow_addr_s;
`ifdef SNN_SCORE_OUT_EN
  logic       score_vld_d, score_vld_s;
  logic [3:0] score_idx_d, score_idx_s;
  logic [7:0] score_d, score_s;
`endif

  snn_core_param u_dut_d (
    .clk(clk), .rst_n(rst_n_d), .start(start_d), .busy(busy_d), .done(done_d),
    .digit(digit_d), .max_score(max_d), .in_addr(in_addr_d), .in_q(in_q_d),
    .hw_addr(hw_addr_d), .hw_q(hw_q_d), .ow_addr(ow_addr_d), .ow_q(ow_q_d),
    .lut_addr(lut_addr_d), .lut_q(lut_q_d)
`ifdef SNN_SCORE_OUT_EN
    , .score_vld(score_vld_d), .score_idx(score_idx_d), .score(score_d)
`endif
  );

  snn_core_param #(.N_IN(4), .N_HID(2), .N_OUT(3), .W_W(8), .ACC_W(20), .FRAC(4), .LUT_AW(8)) u_dut_s (
    .clk(clk), .rst_n(rst_n_s), .start(start_s), .busy(busy_s), .done(done_s),
    .digit(digit_s), .max_score(max_s), .in_addr(in_addr_s), .in_q(in_q_s),
    .hw_addr(hw_addr_s), .hw_q(hw_q_s), .ow_addr(ow_addr_s), .ow_q(ow_q_s),
    .lut_addr(lut_addr_s), .lut_q(lut_q_s)
`ifdef SNN_SCORE_OUT_EN
    , .score_vld(score_vld_s), .score_idx(score_idx_s), .score(score_s)
`endif
  );

  // Default memories: uniform bitmap/weights, per-class output weights, tie-shaped LUT
  logic       bm_d;
  logic [7:0] hw_val_d;

  function automatic logic [7:0] ow_d_fn(input logic [3:0] cls);
    if (cls == 4'd3 || cls == 4'd7) return 8'd80;
    return 8'(4 * (int'(cls) + 1));
  endfunction

  function automatic logic [7:0] lut_d_fn(input logic [10:0] a);
    if (a == 11'h400) return 8'd1;
    if (a == 11'h414) return 8'h50;
    return a[7:0];
  endfunction

  // Small memories: hand-computed net, LUT returns the signed slice
  logic [3:0] bm_s = 4'b1101;
  logic [7:0] hw_s [8] = '{8'd2, 8'd5, 8'd3, 8'hFF, 8'd1, 8'd4, 8'hFE, 8'd6};
  logic [7:0] ow_s [8] = '{8'd10, 8'd20, 8'hE2, 8'd5, 8'hFD, 8'd40, 8'd0, 8'd0};

  always @(posedge clk) begin
    in_q_d  <= bm_d;
    hw_q_d  <= hw_val_d;
    ow_q_d  <= ow_d_fn(4'(ow_addr_d >> 5));
    lut_q_d <= lut_d_fn(lut_addr_d);
    in_q_s  <= bm_s[in_addr_s];
    hw_q_s  <= hw_s[hw_addr_s];
    ow_q_s  <= ow_s[ow_addr_s];
    lut_q_s <= lut_addr_s ^ 8'h80;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  int first, second, ndone, nsc, last_sc;

  initial begin
    rst_n_d = 1'b0; rst_n_s = 1'b0; start_d = 1'b0; start_s = 1'b0;
    bm_d = 1'b0; hw_val_d = 8'h7F;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n_d = 1'b1; rst_n_s = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 32'(busy_d), 0);
    check("rst_done", 32'(done_d), 0);
    check("rst_digit", 32'(digit_d), 0);
    check("rst_max", 32'(max_d), 0);
    check("rst_lut_addr", 32'(lut_addr_d), 0);
    check("rst_hw_addr", 32'(hw_addr_d), 0);

    // Small config with start held: two back-to-back runs
    @(negedge clk); start_s = 1'b1;
    @(posedge clk); #1;
    check("s_busy_start", 32'(busy_s), 1);
    first = -1; second = -1; ndone = 0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (k == 5)  check("s_hid0_lut", 32'(lut_addr_s), 32'h9F);
      if (k == 12) check("s_hid1_lut", 32'(lut_addr_s), 32'hA7);
      if (k == 30) check("s_busy_at_done", 32'(busy_s), 0);
      if (k == 31) begin
        check("s_done_pulse", 32'(done_s), 0);
        check("s_relaunch_busy", 32'(busy_s), 1);
        start_s = 1'b0;
      end
      if (done_s) begin
        ndone++;
        if (first < 0) begin
          first = k;
          check("s_digit", 32'(digit_s), 1);
          check("s_max", 32'(max_s), 32'hD2);
        end else if (second < 0) second = k;
      end
    end
    check("s_latency", 32'(first), 30);
    check("s_relaunch_lat", 32'(second), 61);
    check("s_done_count", 32'(ndone), 2);
    check("s_digit_held", 32'(digit_s), 1);

    // Default size, zero bitmap, tie on classes 3/7, stray start mid-run
    @(negedge clk); start_d = 1'b1;
    @(posedge clk); #1; start_d = 1'b0;
    check("d_busy_start", 32'(busy_d), 1);
    first = -1; ndone = 0; nsc = 0; last_sc = -1;
    for (int k = 1; k <= 25540; k++) begin
      @(posedge clk); #1;
      if (k == 100) start_d = 1'b1;
      else if (k == 101) start_d = 1'b0;
      if (k < 32 * 787 && (k % 787) == 785) check("d_hid_lut", 32'(lut_addr_d), 32'h400);
      if (k == 785) begin
        check("d_in_addr_end", 32'(in_addr_d), 783);
        check("d_hw_addr_end", 32'(hw_addr_d), 783);
      end
      if (done_d) begin
        ndone++;
        if (first < 0) first = k;
      end
`ifdef SNN_SCORE_OUT_EN
      if (score_vld_d) begin
        check("d_score_idx", 32'(score_idx_d), 32'(nsc));
        check("d_score", 32'(score_d), (nsc == 3 || nsc == 7) ? 32'h50 : 32'(nsc + 1));
        nsc++;
        last_sc = k;
      end
`endif
    end
    check("d_latency", 32'(first), 25535);
    check("d_done_count", 32'(ndone), 1);
    check("d_digit_tie", 32'(digit_d), 3);
    check("d_max_tie", 32'(max_d), 32'h50);
    check("d_busy_after", 32'(busy_d), 0);
`ifdef SNN_SCORE_OUT_EN
    check("d_score_count", 32'(nsc), 10);
    check("d_score_last", 32'(last_sc), 32'(first - 1));
`endif

    // Negative saturation, then abort by reset mid H_MAC
    bm_d = 1'b1; hw_val_d = 8'h80;
    @(negedge clk); start_d = 1'b1;
    @(posedge clk); #1; start_d = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 800; k++) begin
      @(posedge clk); #1;
      if (k == 785) check("d_sat_lo", 32'(lut_addr_d), 32'h000);
      if (done_d) ndone++;
    end
    rst_n_d = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy_d), 0);
    check("abort_digit", 32'(digit_d), 0);
    check("abort_max", 32'(max_d), 0);
    repeat (3) begin
      @(posedge clk); #1;
      if (done_d) ndone++;
    end
    @(negedge clk); rst_n_d = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done_d) ndone++;
    end
    check("abort_no_done", 32'(ndone), 0);

    // Positive saturation
    hw_val_d = 8'h7F;
    @(negedge clk); start_d = 1'b1;
    @(posedge clk); #1; start_d = 1'b0;
    for (int k = 1; k <= 785; k++) begin
      @(posedge clk); #1;
      if (k == 785) check("d_sat_hi", 32'(lut_addr_d), 32'h7FF);
    end
    rst_n_d = 1'b0;
    @(posedge clk); #1;
    check("abort2_busy", 32'(busy_d), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/snn_core_param.md
Name: snn_core_param

Overview:
- Parametrised successor of the fixed 784-32-10 SNN inference core.
- Runs a two-layer fully-connected network over a 1-bit input bitmap: hidden MAC, activation LUT, output MAC, then argmax to a class index.
- Layer sizes, weight/accumulator widths and fixed-point position are parameters.
- Weight ROMs, activation LUT and input bitmap sit outside the block on synchronous 1-cycle-latency read ports; the hidden-activation RAM is internal.

Parameters:
N_IN, 784, input units (bitmap bits)
N_HID, 32, hidden units
N_OUT, 10, output classes (2..16)
W_W, 8, signed weight/activation width
ACC_W, 26, signed accumulator width
FRAC, 7, LSB index of the accumulator slice used for the LUT address
LUT_AW, 11, activation LUT address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  start request, sampled in IDLE only
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
digit  out  4  argmax class index, held until next done
max_score  out  W_W  winning activation, held with digit
in_addr  out  clog2(N_IN)  bitmap read address
in_q  in  1  bitmap bit, valid 1 cycle after in_addr
hw_addr  out  clog2(N_HID)+clog2(N_IN)  hidden weight address {hid, in}
hw_q  in  W_W  hidden weight, valid 1 cycle after address
ow_addr  out  clog2(N_OUT)+clog2(N_HID)  output weight address {out, hid}
ow_q  in  W_W  output weight
lut_addr  out  LUT_AW  activation LUT address
lut_q  in  W_W  activation LUT data

Behaviour:
- Reset values: busy=0, done=0, digit=0, max_score=0, all addresses 0, FSM in IDLE, accumulator 0.
- States:
  - IDLE: clear counters and accumulator; if start, go to H_MAC.
  - H_MAC: issue one input per cycle for N_IN cycles.
  - H_DRAIN: last product accumulates.
  - H_LUT: lut_addr driven from accumulator.
  - H_WR: write lut_q to hidden RAM[h] and clear the accumulator. If h<N_HID-1, h++ and go to H_MAC; else go to O_MAC.
  - O_MAC: N_HID issue cycles reading the internal RAM (1-cycle registered read).
  - O_DRAIN, O_LUT: as H_DRAIN, H_LUT.
  - O_CMP: compare lut_q against the running max and clear the accumulator. If o<N_OUT-1, o++ and go to O_MAC; else go to DONE.
  - DONE: pulse done, update digit/max_score, return to IDLE.
- MAC: acc <= acc + sext(a)*sext(w).
  - Hidden layer: a = in_q ? 2^(W_W-1)-1 : 0.
  - Output layer: a = hidden RAM value.
  - acc is cleared at the start of every neuron.
- Rectify: take slice acc[FRAC+LUT_AW-1:FRAC].
  - If acc is positive and above that range, saturate to 2^(LUT_AW-1)-1.
  - If acc is negative and below that range, saturate to -2^(LUT_AW-1).
  - lut_addr = slice + 2^(LUT_AW-1), modulo 2^LUT_AW.
- Argmax:
  - Scores are treated as unsigned.
  - Output 0 loads unconditionally.
  - A later output replaces the max only if strictly greater, so on a tie the lowest index wins.
- Latency: done asserts N_HID*(N_IN+3)+N_OUT*(N_HID+3)+1 cycles after the start-accepting edge (25535 with defaults).
- start while busy is ignored. start held high re-launches on the cycle after DONE.
- rst_n asserted mid-run aborts immediately to reset values; a partial result is never signalled.
- Address counters do not wrap: each terminates at N-1.

Optional Feature:
- Macro: SNN_SCORE_OUT_EN.
- Defined: adds ports score_vld (1), score_idx (4), score (W_W). score_vld pulses in each O_CMP cycle with the class index and lut_q, giving N_OUT pulses per run, all before done.
- Undefined: these ports and their logic are absent. Core behaviour is identical in both builds.

Decomposition:
- Package snn_pkg: state enum type, LUT offset constant, saturation limit functions, clog2-derived width localparams.
- Sub-module: snn_mac (signed multiply-accumulate with synchronous clr; widths W_W/ACC_W).
- The hidden RAM is an inferred array inside the core.

Test Plan:
- Small config N_IN=4, N_HID=2, N_OUT=3 with hand-computed weights and an identity LUT: digit matches the golden model; done arrives at 2*7+3*5+1=30 cycles.
- All-zero bitmap, defaults: hidden acc=0, lut_addr=0x400 for every hidden unit; latency exactly 25535 cycles.
- Tie: output LUT returns 0x50 for classes 3 and 7, lower for all others: digit=3, max_score=0x50.
- Saturation: weights 0x7F with an all-ones bitmap: lut_addr=0x7FF. Weights 0x80 with an all-ones bitmap: lut_addr=0x000.
- start pulsed at cycle 100 of a run: ignored, a single done. rst_n dropped mid H_MAC: busy=0 and digit=0 next cycle, no done.
- With SNN_SCORE_OUT_EN defined: exactly N_OUT score_vld pulses with idx 0..9 ascending, the last one 1 cycle before done.
